// File: rtl/dac_pkg.sv
// Shared constants and types for the serial DAC transmitter.
package dac_pkg;

  localparam int unsigned DAC_DW = 12;

  // Full-scale reference used by benches to convert codes to volts.
  localparam real VREF = 5.0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP,
    ST_LOAD,
    ST_FINISH
  } dac_state_e;

  // The counter covers the bit index and the gap/soc lengths (up to 15).
  function automatic int unsigned cnt_width(input int unsigned dw);
    return $clog2((dw > 16) ? dw : 16);
  endfunction

  localparam int unsigned CNT_W = cnt_width(DAC_DW);

endpackage

// File: rtl/dac_shift_reg.sv
// Parallel-load, MSB-first shift register; zeros fill in from the LSB side.
module dac_shift_reg
  import dac_pkg::*;
#(
  parameter int unsigned DW = DAC_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          shift_i,
  input  logic [DW-1:0] data_i,
  output logic          msb_o
);

  logic [DW-1:0] sr_q;
  logic [DW-1:0] sr_d;

  // Load wins over shift; once a word is fully shifted out the MSB reads 0.
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = {sr_q[DW-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb_o = sr_q[DW-1];

endmodule

// File: rtl/dac_serial_tx.sv
// Serialises a parallel DAC code MSB-first, then strobes soc and pulses done.
module dac_serial_tx
  import dac_pkg::*;
#(
  parameter int unsigned DW         = DAC_DW,
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned SOC_LEN    = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic          SI,
  output logic          SI_en,
  output logic          soc,
  output logic          busy,
  output logic          done
);

  localparam int unsigned CW = cnt_width(DW);
  localparam logic [CW-1:0] BIT_LAST = CW'(DW - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam logic [CW-1:0] SOC_LAST = CW'((SOC_LEN == 0) ? 0 : SOC_LEN - 1);

  dac_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          si_en_q, si_en_d;
  logic          soc_q, soc_d;
  logic          done_q, done_d;
  logic          accept_c;
  logic          shift_c;

  assign accept_c = din_valid & ready_q;
  assign shift_c  = (state_q == ST_SHIFT);

  // Next state; outputs are derived from the next state so they register
  // in step with the state they describe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = ST_SHIFT;
          cnt_d   = BIT_LAST;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == '0) begin
          if (GAP_CYCLES == 0) begin
            state_d = ST_LOAD;
            cnt_d   = SOC_LAST;
          end else begin
            state_d = ST_GAP;
            cnt_d   = GAP_LAST;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_LOAD;
          cnt_d   = SOC_LAST;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_LOAD: begin
        if (cnt_q == '0) begin
          state_d = ST_FINISH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_FINISH: begin
        if (accept_c) begin
          state_d = ST_SHIFT;
          cnt_d   = BIT_LAST;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    ready_d = (state_d == ST_IDLE) || (state_d == ST_FINISH);
    busy_d  = (state_d == ST_SHIFT) || (state_d == ST_GAP) || (state_d == ST_LOAD);
    si_en_d = (state_d == ST_SHIFT);
    soc_d   = (state_d == ST_LOAD);
    done_d  = (state_d == ST_FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      si_en_q <= 1'b0;
      soc_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      si_en_q <= si_en_d;
      soc_q   <= soc_d;
      done_q  <= done_d;
    end
  end

  // The register MSB is SI directly; it is zero outside SHIFT because the
  // word has been shifted out (or cleared by reset) by then.
  dac_shift_reg #(
    .DW(DW)
  ) u_shift_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (accept_c),
    .shift_i(shift_c),
    .data_i (din),
    .msb_o  (SI)
  );

  assign din_ready = ready_q;
  assign busy      = busy_q;
  assign SI_en     = si_en_q;
  assign soc       = soc_q;
  assign done      = done_q;

endmodule
